l1ca_acq_scheduler: RTL

L1CA_ACQ_SCHEDULER -- requirements
Module: l1ca_acq_scheduler

---
 rtl/l1ca_acq_scheduler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/l1ca_acq_scheduler.sv
// Sequences GPS L1 C/A acquisition over a 32-SV mask: a coarse search per SV,
// a fine search when the coarse peak clears the threshold, and one result per SV.
module l1ca_acq_scheduler #(
    parameter int COARSE_WIN = 19200,
    parameter int FINE_WIN   = 192000,
    parameter int TIMEOUT    = 2**20,
    parameter int WORD_W     = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              go,
    input  logic              abort,
    input  logic [31:0]       sv_mask,
    input  logic [WORD_W-1:0] threshold,
    output logic              c_start,
    output logic [4:0]        c_sv,
    input  logic              c_busy,
    input  logic [WORD_W-1:0] c_acc,
    input  logic [10:0]       c_code_idx,
    input  logic [4:0]        c_dop_idx,
    output logic              f_start,
    output logic [4:0]        f_sv,
    output logic [10:0]       f_coarse_code_idx,
    output logic [4:0]        f_coarse_dop_idx,
    input  logic              f_busy,
    input  logic [WORD_W-1:0] f_acc,
    input  logic [12:0]       f_code_idx,
    input  logic [7:0]        f_dop_idx,
    output logic              res_valid,
    output logic [4:0]        res_sv,
    output logic              res_found,
    output logic              res_timeout,
    output logic [WORD_W-1:0] res_acc,
    output logic [12:0]       res_code,
    output logic [7:0]        res_dop,
    output logic              busy,
    output logic              done
);

    // state   | meaning
    // IDLE    | waiting for go
    // SCAN    | test one mask bit per cycle
    // C_RUN   | c_start held for COARSE_WIN cycles
    // C_WAIT  | wait for coarse engine busy to fall (bounded by TIMEOUT)
    // EVAL    | compare captured coarse peak with threshold
    // F_RUN   | f_start held for FINE_WIN cycles
    // F_WAIT  | wait for fine engine busy to fall (bounded by TIMEOUT)
    // REPORT  | res_valid pulse, advance to next SV
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_C_RUN  = 3'd2;
    localparam logic [2:0] S_C_WAIT = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_F_RUN  = 3'd5;
    localparam logic [2:0] S_F_WAIT = 3'd6;
    localparam logic [2:0] S_REPORT = 3'd7;

    localparam int WIN_MAX = (COARSE_WIN > FINE_WIN) ? COARSE_WIN : FINE_WIN;
    localparam int WIN_W   = $clog2(WIN_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    localparam logic [WIN_W-1:0] C_LOAD  = WIN_W'(COARSE_WIN - 1);
    localparam logic [WIN_W-1:0] F_LOAD  = WIN_W'(FINE_WIN - 1);
    localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [4:0]        idx;
    logic [31:0]       mask_q;
    logic [WORD_W-1:0] thr_q;
    logic [WORD_W-1:0] e_acc;
    logic [WIN_W-1:0]  win_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              wait_first;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state             <= S_IDLE;
            idx               <= '0;
            mask_q            <= '0;
            thr_q             <= '0;
            e_acc             <= '0;
            win_cnt           <= '0;
            to_cnt            <= '0;
            wait_first        <= 1'b0;
            c_start           <= 1'b0;
            c_sv              <= '0;
            f_start           <= 1'b0;
            f_sv              <= '0;
            f_coarse_code_idx <= '0;
            f_coarse_dop_idx  <= '0;
            res_valid         <= 1'b0;
            res_sv            <= '0;
            res_found         <= 1'b0;
            res_timeout       <= 1'b0;
            res_acc           <= '0;
            res_code          <= '0;
            res_dop           <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            done      <= 1'b0;
            res_valid <= 1'b0;
            if (abort && state != S_IDLE) begin
                state   <= S_IDLE;
                c_start <= 1'b0;
                f_start <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go) begin
                            mask_q <= sv_mask;
                            thr_q  <= threshold;
                            idx    <= '0;
                            busy   <= 1'b1;
                            state  <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (mask_q[idx]) begin
                            c_sv    <= idx;
                            c_start <= 1'b1;
                            win_cnt <= C_LOAD;
                            state   <= S_C_RUN;
                        end else if (idx == 5'd31) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                    S_C_RUN: begin
                        if (win_cnt == '0) begin
                            c_start    <= 1'b0;
                            to_cnt     <= TO_LOAD;
                            wait_first <= 1'b1;
                            state      <= S_C_WAIT;
                        end else begin
                            win_cnt <= win_cnt - WIN_W'(1);
                        end
                    end
                    S_C_WAIT: begin
                        wait_first <= 1'b0;
                        // engine busy may still be low on the first cycle after start drops
                        if (!wait_first && !c_busy) begin
                            e_acc             <= c_acc;
                            f_coarse_code_idx <= c_code_idx;
                            f_coarse_dop_idx  <= c_dop_idx;
                            f_sv              <= c_sv;
                            state             <= S_EVAL;
                        end else if (to_cnt == '0) begin
                            res_valid   <= 1'b1;
                            res_sv      <= c_sv;
                            res_found   <= 1'b0;
                            res_timeout <= 1'b1;
                            res_acc     <= '0;
                            res_code    <= '0;
                            res_dop     <= '0;
                            state       <= S_REPORT;
                        end else begin
                            to_cnt <= to_cnt - TO_W'(1);
                        end
                    end
                    S_EVAL: begin
                        if (e_acc >= thr_q) begin
                            f_start <= 1'b1;
                            win_cnt <= F_LOAD;
                            state   <= S_F_RUN;
                        end else begin
                            res_valid   <= 1'b1;
                            res_sv      <= c_sv;
                            res_found   <= 1'b0;
                            res_timeout <= 1'b0;
                            res_acc     <= e_acc;
                            res_code    <= {2'b00, f_coarse_code_idx};
                            res_dop     <= {3'b000, f_coarse_dop_idx};
                            state       <= S_REPORT;
                        end
                    end
                    S_F_RUN: begin
                        if (win_cnt == '0) begin
                            f_start    <= 1'b0;
                            to_cnt     <= TO_LOAD;
                            wait_first <= 1'b1;
                            state      <= S_F_WAIT;
                        end else begin
                            win_cnt <= win_cnt - WIN_W'(1);
                        end
                    end
                    S_F_WAIT: begin
                        wait_first <= 1'b0;
                        if (!wait_first && !f_busy) begin
                            res_valid   <= 1'b1;
                            res_sv      <= c_sv;
                            res_found   <= 1'b1;
                            res_timeout <= 1'b0;
                            res_acc     <= f_acc;
                            res_code    <= f_code_idx;
                            res_dop     <= f_dop_idx;
                            state       <= S_REPORT;
                        end else if (to_cnt == '0) begin
                            res_valid   <= 1'b1;
                            res_sv      <= c_sv;
                            res_found   <= 1'b0;
                            res_timeout <= 1'b1;
                            res_acc     <= '0;
                            res_code    <= '0;
                            res_dop     <= '0;
                            state       <= S_REPORT;
                        end else begin
                            to_cnt <= to_cnt - TO_W'(1);
                        end
                    end
                    S_REPORT: begin
                        if (idx == 5'd31) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= S_SCAN;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
